pipe_hazard_ctrl: RTL

Central stall, flush and micro-op sequencing controller for the 16-bit six-stage pipeline (IF, ID, RR, EX, MEM, WB). It inspects the RR-stage instruction and the EX-stage instruction and drives the hold, bubble and flush controls of the PC and the IF/ID, ID/RR and RR/EX pipeline registers. It also breaks load-multiple and store-multiple instructions into one micro-op per register. The top level ORs each flush/bubble output with `rst` into the corresponding pipeline register's clear.

---
 rtl/pipe_ctrl_pkg.sv | 7 +
 rtl/lsb_pick.sv | 18 +
 rtl/pipe_hazard_ctrl.sv | 83 ++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state encoding and default widths for the pipeline controller
package pipe_ctrl_pkg;
  typedef enum logic {IDLE, MULTI} state_t;
  localparam int DEF_REG_IDX_W = 3;
  localparam int DEF_MASK_W = 8;
  localparam int DEF_ADDR_W = 16;
endpackage

// File: rtl/lsb_pick.sv
// lsb_pick: lowest-set-bit index, mask with that bit cleared, and single-bit flag
module lsb_pick #(
  parameter int MASK_W = 8,
  parameter int IDX_W = 3
) (
  input  logic [MASK_W-1:0] mask,
  output logic [IDX_W-1:0]  idx,
  output logic [MASK_W-1:0] rest,
  output logic              one_left
);
  // scan from the top so the lowest set bit is the last one to win
  always_comb begin
    idx = '0;
    for (int i = MASK_W - 1; i >= 0; i--) idx = mask[i] ? IDX_W'(i) : idx;
  end
  assign rest = mask & (mask - 1'b1);
  assign one_left = |mask & ~|rest;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall, flush and LM/SM micro-op sequencing for the six-stage pipeline
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_IDX_W = DEF_REG_IDX_W,
  parameter int MASK_W = DEF_MASK_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rr_valid,
  input  logic [REG_IDX_W-1:0] rr_rs1,
  input  logic [REG_IDX_W-1:0] rr_rs2,
  input  logic                 rr_uses_rs1,
  input  logic                 rr_uses_rs2,
  input  logic                 rr_is_lm,
  input  logic                 rr_is_sm,
  input  logic [MASK_W-1:0]    rr_mask,
  input  logic                 ex_valid,
  input  logic                 ex_is_load,
  input  logic                 ex_wr_en,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 ex_redirect,
  input  logic [ADDR_W-1:0]    ex_target,
  output logic                 hold_pc,
  output logic                 hold_if_id,
  output logic                 hold_id_rr,
  output logic                 bubble_rr_ex,
  output logic                 flush_if_id,
  output logic                 flush_id_rr,
  output logic                 pc_sel,
  output logic [ADDR_W-1:0]    pc_target,
  output logic                 uop_valid,
  output logic [REG_IDX_W-1:0] uop_reg,
  output logic [REG_IDX_W-1:0] uop_offset,
  output logic                 uop_last,
  output logic                 busy
);
  state_t state;
  logic [MASK_W-1:0] rem, pick_in, rest;
  logic [REG_IDX_W-1:0] cnt, idx;
  logic one_left, idle, live, load_use, start, issue, hold;
  assign idle = state == IDLE;
  assign live = ~rst & ~ex_redirect;
  assign pick_in = idle ? rr_mask : rem;
  lsb_pick #(.MASK_W(MASK_W), .IDX_W(REG_IDX_W)) u_pick (
    .mask(pick_in), .idx(idx), .rest(rest), .one_left(one_left)
  );
  assign load_use = live & idle & ex_valid & ex_is_load & ex_wr_en & rr_valid &
                    ((rr_uses_rs1 & rr_rs1 == ex_rd) | (rr_uses_rs2 & rr_rs2 == ex_rd));
  assign start = live & ~load_use & idle & rr_valid & (rr_is_lm | rr_is_sm);
  assign issue = (start | (live & ~idle)) & |pick_in;
  assign hold = load_use | (issue & ~one_left);
  assign hold_pc = hold;
  assign hold_if_id = hold;
  assign hold_id_rr = hold;
  assign bubble_rr_ex = ~rst & (ex_redirect | load_use | (start & ~|rr_mask));
  assign flush_if_id = ~rst & ex_redirect;
  assign flush_id_rr = ~rst & ex_redirect;
  assign pc_sel = ~rst & ex_redirect;
  assign pc_target = ex_target;
  assign uop_valid = issue;
  assign uop_reg = issue ? idx : '0;
  assign uop_offset = (issue & ~idle) ? cnt : '0;
  assign uop_last = issue & one_left;
  assign busy = ~rst & ~idle;
  // sequence state: redirect or reset aborts, multi-bit masks walk rem one bit per cycle
  always_ff @(posedge clk) begin
    if (rst | ex_redirect) begin
      state <= IDLE;
      rem <= '0;
      cnt <= '0;
    end else if (issue & ~one_left) begin
      state <= MULTI;
      rem <= rest;
      cnt <= (idle ? '0 : cnt) + 1'b1;
    end else if (issue) begin
      state <= IDLE;
      rem <= '0;
      cnt <= '0;
    end
  end
endmodule
